addr_fetch_ctrl: RTL
====================

Name: addr_fetch_ctrl

Overview:
Sequencer for the 6502 16-bit address latch (latch_l / latch_h / inc strobes). It fetches a 16-bit address from memory as two byte reads, low byte first, and strobes each byte into the latch. It also issues single latch-increment commands. It sits between the CPU decode logic, which issues commands, and the memory bus, and reports busy, done and timeout status back to decode.

Parameters:
TIMEOUT, 16, consecutive un-acked request cycles before abort; 0 disables timeout; legal range 0..255.
FIX_PAGE_WRAP, 0, 0 = indirect high-byte address wraps within the page (NMOS behaviour); 1 = full 16-bit carry.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  command strobe; sampled only in IDLE.
op  input  2  command: 0 INC, 1 VECTOR, 2 ABS, 3 IND.
vec_sel  input  2  vector select for VECTOR: 0 NMI FFFA, 1 RESET FFFC, 2 IRQ FFFE, 3 BRK FFFE.
addr_in  input  16  base address for ABS/IND; captured at accept.
busy  output  1  high from the cycle after accept through the DONE/ERR cycle.
done  output  1  one-cycle completion pulse.
error  output  1  one-cycle pulse, coincident with done, on timeout.
mem_req  output  1  memory read request.
mem_addr  output  16  read address; 0 when mem_req=0.
mem_ack  input  1  read data valid on the latch data_in this cycle; ignored when mem_req=0.
latch_l  output  1  low-byte load strobe to the latch.
latch_h  output  1  high-byte load strobe to the latch.
inc  output  1  latch increment strobe.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, base=0, wait counter=0, all outputs 0.
- Reset mid-operation:
  - The command is abandoned.
  - mem_req and latch_l/latch_h/inc are forced low combinationally during any cycle in which reset=1.
  - No done pulse is produced.
- States: IDLE, RD_LO, RD_HI, INC, DONE, ERR.
- IDLE:
  - start=1 accepts the command and registers op and base.
  - base = addr_in for ABS/IND; for VECTOR, base = the vec_sel address.
  - op=INC goes to INC; all other ops go to RD_LO.
  - start is ignored in every other state, with no queueing.
- RD_LO:
  - mem_req=1, mem_addr=base.
  - When mem_ack=1: latch_l=1 in that same cycle (Mealy output; data is valid during the ack cycle), then go to RD_HI.
- RD_HI:
  - mem_req=1.
  - mem_addr=base+1 (16-bit) for VECTOR/ABS.
  - For IND: mem_addr={base[15:8], base[7:0]+1} when FIX_PAGE_WRAP=0, else base+1.
  - When mem_ack=1: latch_h=1 in the same cycle, then go to DONE.
- INC: inc=1 for exactly one cycle, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- ERR: done=1 and error=1 for one cycle, then go to IDLE.
- Strobe rules:
  - latch_l, latch_h and inc are mutually exclusive.
  - Each is at most one cycle high per command.
  - They are never high outside RD_LO, RD_HI and INC.
- Wait counter (8-bit):
  - Cleared on entry to RD_LO and RD_HI.
  - Increments each cycle in a read state with mem_ack=0.
  - If TIMEOUT!=0 and the counter equals TIMEOUT-1 in a cycle with mem_ack=0, go to ERR with no strobe.
  - An ack arriving in that same cycle wins: it is processed normally.
- busy = (state != IDLE). busy is deasserted in the cycle after DONE/ERR, so a new start may be accepted in that IDLE cycle.
- Latency with zero-wait memory, where T0 = accept cycle:
  - Reads: RD_LO ack at T1, RD_HI ack at T2, done at T3.
  - INC: inc at T1, done at T2.
  - Each memory wait cycle adds one cycle.
- Arithmetic: all address math is modulo 2^16; base=FFFF gives high address 0000 for ABS.

Test Plan:
- Reset vector, zero-wait ack: op=1, vec_sel=1 -> mem_addr FFFC at T1 with latch_l, FFFD at T2 with latch_h, done at T3; with memory bytes 34/12 the latch holds 1234.
- IND page wrap: addr_in=10FF, op=3, FIX_PAGE_WRAP=0 -> high read at 1000. Rerun with FIX_PAGE_WRAP=1 -> high read at 1100.
- ABS with 2 wait cycles per byte, addr_in=FFFF: reads at FFFF then 0000; done at T7; each strobe high only in its ack cycle.
- INC, then start held high continuously: inc for one cycle, done, then the next command is accepted in the IDLE cycle after DONE; start pulses during busy are ignored (no extra strobes).
- Timeout, TIMEOUT=4, ack never asserted in RD_HI: latch_l once, no latch_h, done=error=1 exactly 4 cycles after RD_HI entry; late ack after that is ignored.
- reset asserted in the RD_HI cycle where ack=1: no latch_h, no done, outputs 0 in that cycle; next cycle IDLE with busy=0.

Source files
------------

// File: rtl/addr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// addr_fetch_ctrl
//
// Sequencer for the 6502 16-bit address latch. A command from decode either
// fetches a 16-bit address as two byte reads (low byte first, strobing the
// latch halves on each ack) or issues a single latch increment. Status
// (busy / done / error) is reported back to decode.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start, op         command strobe and opcode (0 INC, 1 VECTOR, 2 ABS, 3 IND)
//   vec_sel           vector select for VECTOR (NMI, RESET, IRQ, BRK)
//   addr_in           base address for ABS/IND, captured when accepted
//   busy, done, error command status to decode
//   mem_req, mem_addr memory read request and address (0 when idle)
//   mem_ack           read data valid on the latch input this cycle
//   latch_l, latch_h  low/high byte load strobes to the address latch
//   inc               latch increment strobe
//
// Parameters:
//   TIMEOUT        un-acked request cycles before abort (0 = never abort)
//   FIX_PAGE_WRAP  0: IND high-byte read wraps inside the page (NMOS quirk)
//                  1: IND high-byte address uses a full 16-bit carry
// ---------------------------------------------------------------------------
module addr_fetch_ctrl #(
  parameter int unsigned TIMEOUT       = 16,
  parameter bit          FIX_PAGE_WRAP = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [1:0]  vec_sel,
  input  logic [15:0] addr_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  output logic        latch_l,
  output logic        latch_h,
  output logic        inc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_INC,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    OP_INC    = 2'd0,
    OP_VECTOR = 2'd1,
    OP_ABS    = 2'd2,
    OP_IND    = 2'd3
  } op_t;

  // Value of the wait counter in the last cycle an ack may still arrive.
  localparam bit         TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [7:0] TMO_LAST   = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [15:0] base_q, base_d;
  logic [7:0]  wait_q, wait_d;

  // Combinational outputs before the reset override.
  logic        busy_c, done_c, error_c, req_c;
  logic [15:0] addr_c;
  logic        latch_l_c, latch_h_c, inc_c;

  logic [15:0] vec_addr;
  logic [15:0] hi_addr;
  logic [7:0]  lo_plus1;
  logic        timeout_hit;

  // Hardware vector table.
  always_comb begin
    unique case (vec_sel)
      2'd0:    vec_addr = 16'hFFFA;  // NMI
      2'd1:    vec_addr = 16'hFFFC;  // RESET
      default: vec_addr = 16'hFFFE;  // IRQ and BRK share a vector
    endcase
  end

  // High-byte read address. Indirect fetches on NMOS parts do not carry
  // into the page byte, so a pointer at xxFF reads its high byte from xx00.
  assign lo_plus1 = base_q[7:0] + 8'd1;

  always_comb begin
    if (op_q == OP_IND && !FIX_PAGE_WRAP) begin
      hi_addr = {base_q[15:8], lo_plus1};
    end else begin
      hi_addr = base_q + 16'd1;
    end
  end

  // An ack in the final allowed cycle takes priority over the abort.
  assign timeout_hit = TIMEOUT_EN && (wait_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    base_d    = base_q;
    wait_d    = wait_q;
    done_c    = 1'b0;
    error_c   = 1'b0;
    req_c     = 1'b0;
    addr_c    = 16'h0000;
    latch_l_c = 1'b0;
    latch_h_c = 1'b0;
    inc_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op_t'(op);
          base_d = (op_t'(op) == OP_VECTOR) ? vec_addr : addr_in;
          wait_d = 8'd0;
          state_d = (op_t'(op) == OP_INC) ? S_INC : S_RD_LO;
        end
      end

      S_RD_LO: begin
        req_c  = 1'b1;
        addr_c = base_q;
        if (mem_ack) begin
          latch_l_c = 1'b1;
          wait_d    = 8'd0;
          state_d   = S_RD_HI;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_RD_HI: begin
        req_c  = 1'b1;
        addr_c = hi_addr;
        if (mem_ack) begin
          latch_h_c = 1'b1;
          state_d   = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_INC: begin
        inc_c   = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end

      S_ERR: begin
        done_c  = 1'b1;
        error_c = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_c = (state_q != S_IDLE);

  // While reset is held, nothing may reach the bus or the latch, even though
  // the state register still holds the abandoned command until the edge.
  assign busy     = busy_c    & ~reset;
  assign done     = done_c    & ~reset;
  assign error    = error_c   & ~reset;
  assign mem_req  = req_c     & ~reset;
  assign mem_addr = reset ? 16'h0000 : addr_c;
  assign latch_l  = latch_l_c & ~reset;
  assign latch_h  = latch_h_c & ~reset;
  assign inc      = inc_c     & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_INC;
      base_q  <= 16'h0000;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      base_q  <= base_d;
      wait_q  <= wait_d;
    end
  end

endmodule
